// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// quad_decoder: synchronizes, glitch-filters and decodes A/B quadrature phases.
// Revision: 1.0
// ============================================================================
module quad_decoder #(
  parameter int COUNT_WIDTH = 16,
  parameter int FILTER_LEN  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_in,
  input  logic                   b_in,
  input  logic                   clear,
  input  logic                   err_clr,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   dir,
  output logic                   step,
  output logic                   err,
  output logic                   ready
);

  localparam int                     c_fc_w    = $clog2(FILTER_LEN + 1);
  localparam logic [c_fc_w-1:0]      c_fc_last = c_fc_w'(FILTER_LEN - 1);
  localparam logic [c_fc_w-1:0]      c_fc_one  = c_fc_w'(1);
  localparam logic [COUNT_WIDTH-1:0] c_cnt_one = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Phase vectors are packed as {A, B}.
  logic [1:0]        r_ff1;
  logic [1:0]        r_ff2;
  logic [1:0]        r_filt;
  logic [c_fc_w-1:0] r_fc [2];
  logic [1:0]        r_prev;
  logic [1:0]        r_fill_cnt;
  state_t            r_state;

  logic [1:0] w_diff;
  logic       w_fwd;
  logic       w_illegal;

  assign w_diff    = r_prev ^ r_filt;
  // Forward Gray order 00->10->11->01: new B always equals old A.
  assign w_fwd     = (r_prev[1] == r_filt[0]);
  assign w_illegal = (w_diff == 2'b11);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_filt <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_fc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_state == S_LOAD) begin
          r_filt[i] <= r_ff2[i];
          r_fc[i]   <= '0;
        end else if (r_ff2[i] == r_filt[i]) begin
          r_fc[i] <= '0;
        end else if (r_fc[i] == c_fc_last) begin
          r_filt[i] <= r_ff2[i];
          r_fc[i]   <= '0;
        end else begin
          r_fc[i] <= r_fc[i] + c_fc_one;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ff1      <= 2'b00;
      r_ff2      <= 2'b00;
      r_prev     <= 2'b00;
      r_fill_cnt <= 2'd0;
      r_state    <= S_FILL;
      count      <= '0;
      dir        <= 1'b0;
      step       <= 1'b0;
      err        <= 1'b0;
      ready      <= 1'b0;
    end else begin
      r_ff1 <= {a_in, b_in};
      r_ff2 <= r_ff1;
      step  <= 1'b0;
      if (err_clr) begin
        err <= 1'b0;
      end
      case (r_state)
        S_FILL: begin
          if (r_fill_cnt == 2'd1) begin
            r_state <= S_LOAD;
          end else begin
            r_fill_cnt <= r_fill_cnt + 2'd1;
          end
        end
        S_LOAD: begin
          r_prev  <= r_ff2;
          r_state <= S_RUN;
          ready   <= 1'b1;
        end
        S_RUN: begin
          r_prev <= r_filt;
          if (w_illegal) begin
            err <= 1'b1;
          end else if (w_diff != 2'b00) begin
            step  <= 1'b1;
            dir   <= w_fwd;
            count <= w_fwd ? count + c_cnt_one : count - c_cnt_one;
          end
        end
        default: begin
          r_state <= S_FILL;
        end
      endcase
      // Clear wins over a coincident step; step/dir still report it.
      if (clear) begin
        count <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/quad_decoder.md
# quad_decoder

Quadrature encoder controller for the icestick quadrature design. It takes the raw, asynchronous A/B encoder phases and brings them into the `clk` domain through an internal two-flop synchronizer per phase. It then glitch-filters each phase and decodes the Gray-code transitions into a wrapping signed-free position count, with a direction flag, a step strobe and a sticky illegal-transition error. It sits between the encoder pins and the host-visible register file.

## Interface
- `COUNT_WIDTH`, 16: width of the position counter.
- `FILTER_LEN`, 4: consecutive cycles a synchronized phase must differ from its filtered level before the filtered level changes. Legal range 1..255; 1 means no filtering.

Ports:
- `clk`  in  1  single clock; every flop is on its rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `a_in`  in  1  encoder phase A, asynchronous.
- `b_in`  in  1  encoder phase B, asynchronous.
- `clear`  in  1  synchronous pulse; zeroes `count`.
- `err_clr`  in  1  synchronous pulse; clears `err`.
- `count`  out  COUNT_WIDTH  position, modulo 2^COUNT_WIDTH.
- `dir`  out  1  direction of last legal step: 1 = forward, 0 = reverse.
- `step`  out  1  one-cycle strobe on each legal step.
- `err`  out  1  sticky: a double-phase transition was seen.
- `ready`  out  1  high once the decoder is in RUN.

## Operation
- **Synchronizer.** There are two flops per phase (`ff1`, `ff2`). `ff2` is the synchronized level `s_a`/`s_b`.
- **Filter.** Each phase has its own filtered level `f_x` and a counter `fc_x` of width ceil(log2(FILTER_LEN+1)).
  - If `s_x == f_x`: `fc_x <= 0`.
  - Otherwise `fc_x` increments.
  - On the FILTER_LEN-th consecutive differing edge: `f_x <= s_x` and `fc_x <= 0`.
  - The A and B filters run independently.
- **FSM states.**
  - FILL: entered on reset. A 2-bit counter waits 2 cycles for the synchronizer to fill, then goes to LOAD.
  - LOAD: one cycle. `f_a <= s_a`, `f_b <= s_b`, `prev <= {s_a, s_b}`, no count change, then go to RUN.
  - RUN: `ready` = 1. Each cycle, compare `prev` with `cur = {f_a, f_b}`:
    - Unchanged: nothing happens.
    - Forward (00→10→11→01→00): `count` +1, `dir` <= 1, `step` = 1.
    - Reverse (00→01→11→10→00): `count` −1, `dir` <= 0, `step` = 1.
    - Both bits changed: `err` <= 1; `count` and `dir` unchanged; `step` = 0.
    - In every case `prev <= cur`.
- **Arithmetic.** `count` is unsigned modulo 2^COUNT_WIDTH. 0 − 1 wraps to all-ones; all-ones + 1 wraps to 0.
- **Priorities.**
  - `clear` coinciding with a step: `count` becomes 0. The step is lost, but `step` and `dir` still reflect it.
  - `err_clr` coinciding with a new illegal transition: `err` stays 1.
  - `clear` and `err_clr` act in every state.
- **Reset.** Reset mid-operation abandons all state immediately and re-enters FILL.

## Timing
- **Reset values.** `count` = 0, `dir` = 0, `step` = 0, `err` = 0, `ready` = 0. Synchronizer flops, filtered levels, `fc_x` and `prev` all reset to 0.
- **Start-up.**
  - After the first edge with `rst_n` = 1: 2 cycles in FILL, 1 in LOAD.
  - `ready` rises on the 3rd edge with `rst_n` high.
  - The encoder's rest position is adopted silently in LOAD, so a shaft at 11 after reset counts nothing and raises no error.
- **Latency** from a phase change, for a change set up before edge E:
  - Captured by `ff1` at E and by `ff2` at E+1.
  - `f_x` changes at E+1+FILTER_LEN.
  - `count`, `dir`, `step` update at E+2+FILTER_LEN. With the default, that is 6 edges after E.
- **Glitches.** A synchronized pulse shorter than FILTER_LEN cycles never changes `f_x` and produces no step.
- **Throughput.** One step per cycle at most. Minimum legal phase spacing is FILTER_LEN cycles.
- **Simultaneous edges.** A and B changing in the same cycle at the pins may reach `f_a`/`f_b` on the same edge. That is reported as `err`, by design.
- **Registered outputs.** All outputs come straight from flops; there is no combinational path from inputs to outputs.

## Test plan
- **Forward steps.** Reset, then wait for `ready`. Drive AB 00→10→11→01→00 with 10-cycle spacing → `count` = 4, `dir` = 1, exactly 4 single-cycle `step` pulses. Each pulse lands 6 cycles after its pin change (FILTER_LEN = 4).
- **Reverse and wrap.** From `count` = 0, drive 00→01→11→10 → `count` = 0xFFFD, `dir` = 0, `err` = 0.
- **Glitch rejection.** Pulse `a_in` high for 3 cycles with FILTER_LEN = 4 → no `step`, `count` unchanged. Repeat with a 4-cycle pulse → `count` +1, then −1.
- **Illegal transition.** Drive 00→11 on the same edge → `err` = 1, `count` unchanged, `step` = 0. Pulse `err_clr` → `err` = 0. Pulse `err_clr` on the same cycle as a second 11→00 → `err` stays 1.
- **Clear versus step.** Assert `clear` on the exact cycle a forward step decodes, with `count` = 7 → `count` = 0, `step` = 1, `dir` = 1.
- **Reset mid-operation.** With `count` = 0x1234 and a transition in flight, hold `rst_n` low for 1 cycle while the pins sit at 11 → all outputs return to their reset values. `ready` returns 3 edges after release, `count` = 0, and the pipeline adopts 11 with no `step` and no `err`.
